// File: rtl/param_mc_alu_if.sv
// Request/response bundle for param_mc_alu: operands and op in, registered results and handshake out.
interface param_mc_alu_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 10
);
    logic              start;
    logic [3:0]        op;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic              busy;
    logic              done;
    logic [WIDTH-1:0]  result;
    logic [WIDTH-1:0]  result_hi;
    logic              zero;
    logic              overflow;
    logic [ADDR_W-1:0] dm_addr;

    modport master (
        output start, op, a, b,
        input  busy, done, result, result_hi, zero, overflow, dm_addr
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result, result_hi, zero, overflow, dm_addr
    );
endinterface

// File: rtl/param_mc_alu.sv
// Multi-cycle ALU: single-cycle logic/arith ops plus iterative shift-add multiply and restoring divide.
module param_mc_alu #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 10
) (
    input logic           clk,
    input logic           rst,
    param_mc_alu_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t           state;
    logic [WIDTH-1:0] opa, hi_acc, lo_acc;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] result_q, hi_q;
    logic             zero_q, ovf_q, busy_q, done_q;

    logic [WIDTH-1:0] sum, diff, sc_res;
    logic             sc_ovf;

    always_comb begin
        sum    = bus.a + bus.b;
        diff   = bus.a - bus.b;
        sc_res = '0;
        sc_ovf = 1'b0;
        case (bus.op)
            4'b0000: sc_res = sum;
            4'b0001: sc_res = diff;
            4'b0010: sc_res = bus.a | bus.b;
            4'b0011: begin
                sc_res = sum;
                sc_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            4'b0100: sc_res = bus.a & bus.b;
            4'b0101: sc_res = WIDTH'($signed(bus.a) < $signed(bus.b));
            4'b0110: sc_res = WIDTH'(bus.a < bus.b);
            4'b0111: sc_res = bus.a ^ bus.b;
            4'b1010: begin
                sc_res = diff;
                sc_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
            end
            4'b1011: sc_res = ~(bus.a | bus.b);
            default: sc_res = '0;
        endcase
    end

    // Multiply: {hi_acc,lo_acc} holds partial product above the unconsumed multiplier bits.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_nx, mul_lo_nx;
    // Divide: hi_acc is the remainder, lo_acc shifts dividend out and quotient in.
    // Since remainder < divisor, bit WIDTH of the trial difference is a clean borrow flag.
    logic [WIDTH:0]   div_shift, div_trial;
    logic             div_ge;
    logic [WIDTH-1:0] div_rem_nx, div_quo_nx;

    always_comb begin
        mul_sum    = {1'b0, hi_acc} + {1'b0, (lo_acc[0] ? opa : '0)};
        mul_hi_nx  = mul_sum[WIDTH:1];
        mul_lo_nx  = {mul_sum[0], lo_acc[WIDTH-1:1]};
        div_shift  = {hi_acc, lo_acc[WIDTH-1]};
        div_trial  = div_shift - {1'b0, opa};
        div_ge     = ~div_trial[WIDTH];
        div_rem_nx = div_ge ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
        div_quo_nx = {lo_acc[WIDTH-2:0], div_ge};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            opa      <= '0;
            hi_acc   <= '0;
            lo_acc   <= '0;
            count    <= '0;
            result_q <= '0;
            hi_q     <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.op == 4'b1000) begin
                            state  <= MUL;
                            busy_q <= 1'b1;
                            opa    <= bus.a;
                            hi_acc <= '0;
                            lo_acc <= bus.b;
                            count  <= '0;
                        end else if (bus.op == 4'b1001 && bus.b != '0) begin
                            state  <= DIV;
                            busy_q <= 1'b1;
                            opa    <= bus.b;
                            hi_acc <= '0;
                            lo_acc <= bus.a;
                            count  <= '0;
                        end else if (bus.op == 4'b1001) begin
                            result_q <= '1;
                            hi_q     <= bus.a;
                            zero_q   <= 1'b0;
                            ovf_q    <= 1'b1;
                            done_q   <= 1'b1;
                        end else begin
                            result_q <= sc_res;
                            hi_q     <= '0;
                            zero_q   <= (sc_res == '0);
                            ovf_q    <= sc_ovf;
                            done_q   <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    hi_acc <= mul_hi_nx;
                    lo_acc <= mul_lo_nx;
                    count  <= count + 1'b1;
                    if (count == LAST) begin
                        state    <= IDLE;
                        result_q <= mul_lo_nx;
                        hi_q     <= mul_hi_nx;
                        zero_q   <= (mul_lo_nx == '0);
                        ovf_q    <= 1'b0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                    end
                end
                DIV: begin
                    hi_acc <= div_rem_nx;
                    lo_acc <= div_quo_nx;
                    count  <= count + 1'b1;
                    if (count == LAST) begin
                        state    <= IDLE;
                        result_q <= div_quo_nx;
                        hi_q     <= div_rem_nx;
                        zero_q   <= (div_quo_nx == '0);
                        ovf_q    <= 1'b0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.result    = result_q;
    assign bus.result_hi = hi_q;
    assign bus.zero      = zero_q;
    assign bus.overflow  = ovf_q;
    assign bus.dm_addr   = result_q[ADDR_W-1:0];
endmodule

// File: tb/tb_param_mc_alu.sv
// Bench for param_mc_alu: vector table through a scoreboard, plus timing/abort sequences and an 8-bit instance.
module tb_param_mc_alu;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    param_mc_alu_if #(.WIDTH(32), .ADDR_W(10)) bus32 ();
    param_mc_alu_if #(.WIDTH(8),  .ADDR_W(4))  bus8 ();

    param_mc_alu #(.WIDTH(32), .ADDR_W(10)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
    param_mc_alu #(.WIDTH(8),  .ADDR_W(4))  dut8  (.clk(clk), .rst(rst), .bus(bus8));

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, b, res, hi;
        logic        ovf;
    } vec_t;

    typedef struct {
        logic [31:0] res, hi;
        logic        zero, ovf;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    vec_t tbl[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(input logic [3:0] op, input logic [31:0] a, b, res, hi, input logic ovf);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.res = res; v.hi = hi; v.ovf = ovf;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // Scoreboard: every done on the 32-bit instance must match the oldest pending expectation.
    always @(negedge clk) begin
        if (!rst && bus32.done === 1'b1) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done: got done=1, expected no pending op");
            end else begin
                e = sb.pop_front();
                chk("result",    bus32.result,    e.res);
                chk("result_hi", bus32.result_hi, e.hi);
                chk("zero",      bus32.zero,      e.zero);
                chk("overflow",  bus32.overflow,  e.ovf);
                chk("dm_addr",   bus32.dm_addr,   e.res[9:0]);
                chk("busy_at_done", bus32.busy,   1'b0);
            end
        end
    end

    task automatic drive32(input logic [3:0] op, input logic [31:0] a, b);
        @(negedge clk);
        bus32.start = 1'b1; bus32.op = op; bus32.a = a; bus32.b = b;
        @(posedge clk);
        #1 bus32.start = 1'b0;
    endtask

    task automatic push_exp(input logic [31:0] res, hi, input logic ovf);
        exp_t x;
        x.res = res; x.hi = hi; x.zero = (res == 32'h0); x.ovf = ovf;
        sb.push_back(x);
    endtask

    task automatic issue32(input vec_t v);
        push_exp(v.res, v.hi, v.ovf);
        drive32(v.op, v.a, v.b);
    endtask

    task automatic wait_not_busy32();
        int n = 0;
        while (bus32.busy && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (bus32.busy) fail_timeout("busy32");
    endtask

    task automatic drive8(input logic [3:0] op, input logic [7:0] a, b);
        @(negedge clk);
        bus8.start = 1'b1; bus8.op = op; bus8.a = a; bus8.b = b;
        @(posedge clk);
        #1 bus8.start = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, busy_cnt;
        logic [31:0] ra, rb;
        logic [63:0] p;

        tbl.push_back(mk(4'h3, 32'h7FFFFFFF, 32'h1, 32'h80000000, 32'h0, 1'b1));
        tbl.push_back(mk(4'h0, 32'h7FFFFFFF, 32'h1, 32'h80000000, 32'h0, 1'b0));
        tbl.push_back(mk(4'h1, 32'h5, 32'h5, 32'h0, 32'h0, 1'b0));
        tbl.push_back(mk(4'h5, 32'hFFFFFFFF, 32'h1, 32'h1, 32'h0, 1'b0));
        tbl.push_back(mk(4'h6, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0, 1'b0));
        tbl.push_back(mk(4'hA, 32'h80000000, 32'h1, 32'h7FFFFFFF, 32'h0, 1'b1));
        tbl.push_back(mk(4'h2, 32'hF0F00000, 32'h00000F0F, 32'hF0F00F0F, 32'h0, 1'b0));
        tbl.push_back(mk(4'h4, 32'hFF00FF00, 32'h0F0F0F0F, 32'h0F000F00, 32'h0, 1'b0));
        tbl.push_back(mk(4'h7, 32'hAAAA5555, 32'hFFFF0000, 32'h55555555, 32'h0, 1'b0));
        tbl.push_back(mk(4'hB, 32'h0, 32'h0, 32'hFFFFFFFF, 32'h0, 1'b0));
        tbl.push_back(mk(4'hB, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0, 1'b0));
        tbl.push_back(mk(4'hC, 32'h5, 32'h6, 32'h0, 32'h0, 1'b0));
        tbl.push_back(mk(4'hF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 1'b0));
        tbl.push_back(mk(4'h3, 32'h80000000, 32'h80000000, 32'h0, 32'h0, 1'b1));
        tbl.push_back(mk(4'hA, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h0, 1'b1));
        tbl.push_back(mk(4'hA, 32'h5, 32'h3, 32'h2, 32'h0, 1'b0));
        tbl.push_back(mk(4'h0, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0, 1'b0));
        tbl.push_back(mk(4'h5, 32'h1, 32'hFFFFFFFF, 32'h0, 32'h0, 1'b0));
        tbl.push_back(mk(4'h6, 32'h1, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b0));
        tbl.push_back(mk(4'h8, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFE, 32'h1, 1'b0));
        tbl.push_back(mk(4'h9, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0));
        tbl.push_back(mk(4'h9, 32'd9, 32'd0, 32'hFFFFFFFF, 32'd9, 1'b1));
        tbl.push_back(mk(4'h8, 32'h0, 32'h5, 32'h0, 32'h0, 1'b0));
        tbl.push_back(mk(4'h9, 32'd3, 32'd10, 32'h0, 32'd3, 1'b0));
        tbl.push_back(mk(4'h8, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 32'hFFFFFFFE, 1'b0));
        tbl.push_back(mk(4'h9, 32'hFFFFFFFF, 32'h1, 32'hFFFFFFFF, 32'h0, 1'b0));
        tbl.push_back(mk(4'h0, 32'h3, 32'h4, 32'h7, 32'h0, 1'b0));

        rst = 1'b1;
        bus32.start = 1'b0; bus32.op = '0; bus32.a = '0; bus32.b = '0;
        bus8.start  = 1'b0; bus8.op  = '0; bus8.a  = '0; bus8.b  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy",   bus32.busy,      1'b0);
        chk("rst_done",   bus32.done,      1'b0);
        chk("rst_result", bus32.result,    32'h0);
        chk("rst_hi",     bus32.result_hi, 32'h0);
        chk("rst_zero",   bus32.zero,      1'b0);
        chk("rst_ovf",    bus32.overflow,  1'b0);
        chk("rst8_result", bus8.result,    8'h0);
        rst = 1'b0;

        // Table: single-cycle ops go back-to-back, iterative ops are followed by a wait on busy.
        for (int i = 0; i < tbl.size(); i++) begin
            issue32(tbl[i]);
            wait_not_busy32();
        end

        // ADDS: one-cycle latency, busy never rises, done is a single pulse.
        push_exp(32'h80000000, 32'h0, 1'b1);
        drive32(4'h3, 32'h7FFFFFFF, 32'h1);
        chk("adds_done_lat1", bus32.done, 1'b1);
        chk("adds_busy",      bus32.busy, 1'b0);
        @(posedge clk); #1;
        chk("adds_done_pulse", bus32.done, 1'b0);

        // MULTU latency, busy duration, and an ignored start mid-operation.
        push_exp(32'hFFFFFFFE, 32'h1, 1'b0);
        drive32(4'h8, 32'hFFFFFFFF, 32'h2);
        n = 1;
        busy_cnt = 0;
        while (!bus32.done && n < 100) begin
            if (bus32.busy) busy_cnt++;
            if (n == 10) begin
                bus32.start = 1'b1; bus32.op = 4'h0; bus32.a = 32'h1; bus32.b = 32'h1;
            end
            if (n == 11) bus32.start = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        if (!bus32.done) fail_timeout("mul_done");
        chk("mul_latency",  n,        33);
        chk("mul_busy_cyc", busy_cnt, 32);
        @(posedge clk); #1;
        chk("mul_done_pulse", bus32.done, 1'b0);
        repeat (3) @(posedge clk);
        #1;

        // DIVU by zero completes in one cycle without busy.
        push_exp(32'hFFFFFFFF, 32'd9, 1'b1);
        drive32(4'h9, 32'd9, 32'd0);
        chk("div0_done_lat1", bus32.done, 1'b1);
        chk("div0_busy",      bus32.busy, 1'b0);

        // Reset during DIVU iteration 10 aborts it with no done.
        drive32(4'h9, 32'd100, 32'd7);
        repeat (9) @(posedge clk);
        #1;
        chk("abort_busy_before", bus32.busy, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy",   bus32.busy,      1'b0);
        chk("abort_done",   bus32.done,      1'b0);
        chk("abort_result", bus32.result,    32'h0);
        chk("abort_hi",     bus32.result_hi, 32'h0);
        chk("abort_ovf",    bus32.overflow,  1'b0);
        @(posedge clk); #1;
        chk("abort_no_done", bus32.done, 1'b0);
        issue32(mk(4'h0, 32'h3FF, 32'h1, 32'h400, 32'h0, 1'b0));
        chk("dm_addr_wrap", bus32.dm_addr, 10'h000);

        // Random iterative ops against a behavioural reference.
        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 2 == 0) begin
                p = {32'h0, ra} * {32'h0, rb};
                issue32(mk(4'h8, ra, rb, p[31:0], p[63:32], 1'b0));
            end else begin
                rb = 32'($urandom_range(1, 5000));
                issue32(mk(4'h9, ra, rb, ra / rb, ra % rb, 1'b0));
            end
            wait_not_busy32();
        end

        // 8-bit instance.
        drive8(4'h8, 8'hFF, 8'hFF);
        n = 1;
        while (!bus8.done && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus8.done) fail_timeout("mul8_done");
        chk("mul8_latency", n,              9);
        chk("mul8_lo",      bus8.result,    8'h01);
        chk("mul8_hi",      bus8.result_hi, 8'hFE);
        drive8(4'h9, 8'd200, 8'd13);
        n = 1;
        while (!bus8.done && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus8.done) fail_timeout("div8_done");
        chk("div8_latency", n,              9);
        chk("div8_quo",     bus8.result,    8'd15);
        chk("div8_rem",     bus8.result_hi, 8'd5);
        chk("div8_dm_addr", bus8.dm_addr,   4'hF);

        repeat (4) @(posedge clk);
        #1;
        chk("sb_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
